// File: rtl/ann_neuron_seq.sv
// Sequencer feeding the ANN MAC: streams features, weights and a bias term per neuron,
// then waits out the MAC pipeline, captures the dot product and clears the accumulator.
module ann_neuron_seq #(
    parameter int DW      = 32,
    parameter int IN_AW   = 10,
    parameter int W_AW    = 16,
    parameter int NEU_W   = 8,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 3
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic [IN_AW-1:0] iNum_inputs,
    input  logic [NEU_W-1:0] iNum_neurons,
    output logic [IN_AW-1:0] oIn_addr,
    input  logic [DW-1:0]    iIn_data,
    output logic [W_AW-1:0]  oW_addr,
    input  logic [DW-1:0]    iW_data,
    output logic             oMac_input_ready,
    output logic             oMac_finish,
    output logic [DW-1:0]    oMac_data,
    output logic [DW-1:0]    oMac_weight,
    input  logic [DW-1:0]    iMac_result,
    output logic [DW-1:0]    oResult,
    output logic [NEU_W-1:0] oResult_idx,
    output logic             oResult_valid,
    output logic             oBusy,
    output logic             oDone
);
    localparam int DCW = $clog2(MEM_LAT + MAC_LAT + 1);
    localparam logic [DCW-1:0] DRAIN_LD = DCW'(MEM_LAT + MAC_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_CAPTURE, S_NEXT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IN_AW-1:0] num_in;
    logic [NEU_W-1:0] num_neu;
    logic [IN_AW-1:0] term_idx;
    logic [W_AW-1:0]  w_ptr;
    logic [NEU_W-1:0] neu_idx;
    logic [DCW-1:0]   drain_cnt;
    logic [MEM_LAT-1:0] pipe_vld;
    logic [MEM_LAT-1:0] pipe_bias;
    logic issue;
    logic last_term;

    assign last_term = (term_idx == num_in);
    assign oIn_addr  = term_idx;
    assign oW_addr   = w_ptr;

    always_ff @(posedge iClk) begin
        if (iReset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (iStart) state_nxt = (iNum_neurons == '0) ? S_DONE : S_CLEAR;
            S_CLEAR:   state_nxt = S_ISSUE;
            S_ISSUE:   if (last_term) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt <= DCW'(1)) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_NEXT;
            S_NEXT:    state_nxt = (({1'b0, neu_idx} + 1'b1) == {1'b0, num_neu}) ? S_DONE : S_ISSUE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue       = (state == S_ISSUE);
        oMac_finish = (state == S_CLEAR) || (state == S_CAPTURE);
        oBusy       = (state != S_IDLE);
        oDone       = (state == S_DONE);
    end

    // Counters and result capture; the weight pointer runs across neurons.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            num_in        <= '0;
            num_neu       <= '0;
            term_idx      <= '0;
            w_ptr         <= '0;
            neu_idx       <= '0;
            drain_cnt     <= '0;
            oResult       <= '0;
            oResult_idx   <= '0;
            oResult_valid <= 1'b0;
        end else begin
            oResult_valid <= (state == S_CAPTURE);
            case (state)
                S_IDLE: if (iStart) begin
                    num_in   <= iNum_inputs;
                    num_neu  <= iNum_neurons;
                    term_idx <= '0;
                    w_ptr    <= '0;
                    neu_idx  <= '0;
                end
                S_ISSUE: begin
                    w_ptr <= w_ptr + 1'b1;
                    if (last_term) begin
                        term_idx  <= '0;
                        drain_cnt <= DRAIN_LD;
                    end else begin
                        term_idx <= term_idx + 1'b1;
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt - 1'b1;
                S_CAPTURE: begin
                    oResult     <= iMac_result;
                    oResult_idx <= neu_idx;
                end
                S_NEXT: neu_idx <= neu_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Term tags follow the memory read latency so operands line up with their data.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            pipe_vld         <= '0;
            pipe_bias        <= '0;
            oMac_input_ready <= 1'b0;
            oMac_data        <= '0;
            oMac_weight      <= '0;
        end else begin
            pipe_vld[0]  <= issue;
            pipe_bias[0] <= issue && last_term;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_bias[i] <= pipe_bias[i-1];
            end
            oMac_input_ready <= pipe_vld[MEM_LAT-1];
            if (pipe_vld[MEM_LAT-1]) begin
                oMac_data   <= pipe_bias[MEM_LAT-1] ? DW'(1) : iIn_data;
                oMac_weight <= iW_data;
            end else begin
                oMac_data   <= '0;
                oMac_weight <= '0;
            end
        end
    end
endmodule
